// File: rtl/fp_unpacker_pipe.sv
// fp_unpacker_pipe: two-stage, multi-lane IEEE-754 field unpacker with
// valid/ready flow control. Each lane is split into sign, unbiased exponent
// and significand (hidden bit explicit) and classified.
// Stage 1 registers the raw fields and the class flags. Stage 2 computes the
// exponent and significand and holds the output registers.
// Optional feature macro: FP_UNPACK_SUBNORM_NORM_EN
//   defined   -> subnormals are normalised with a leading-zero count and shift
//   undefined -> denormals-are-zero: a subnormal reports zero=1 and sub=1,
//                with exp = 0 and sig = 0
module fp_unpacker_pipe #(
  parameter int LANES  = 4,
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*(1+EXP_W+MANT_W)-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES-1:0]                out_sign,
  output logic [LANES*(EXP_W+2)-1:0]      out_exp,
  output logic [LANES*(MANT_W+1)-1:0]     out_sig,
  output logic [LANES-1:0]                out_zero,
  output logic [LANES-1:0]                out_sub,
  output logic [LANES-1:0]                out_inf,
  output logic [LANES-1:0]                out_nan,
  output logic [LANES-1:0]                out_snan
);

  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int XW = EXP_W + 2;
  localparam int SW = MANT_W + 1;
  localparam logic [XW-1:0] BIAS        = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EXP_SPECIAL = XW'(1 << (EXP_W - 1));

  // Lane views of the packed input, lane 0 in the LSBs
  logic [LANES-1:0][W-1:0]      in_lane;
  logic [LANES-1:0]             in_s;
  logic [LANES-1:0][EXP_W-1:0]  in_e;
  logic [LANES-1:0][MANT_W-1:0] in_m;

  assign in_lane = in_data;

  for (genvar g = 0; g < LANES; g++) begin : g_split
    assign in_s[g] = in_lane[g][W-1];
    assign in_e[g] = in_lane[g][W-2 -: EXP_W];
    assign in_m[g] = in_lane[g][MANT_W-1:0];
  end

  // Class flags computed from the incoming fields
  logic [LANES-1:0] c_zero, c_sub, c_inf, c_nan, c_snan;

  // Stage 1 registers
  logic                         s1_valid;
  logic [LANES-1:0]             s1_sign;
  logic [LANES-1:0][EXP_W-1:0]  s1_exp;
  logic [LANES-1:0][MANT_W-1:0] s1_mant;
  logic [LANES-1:0]             s1_zero, s1_sub, s1_inf, s1_nan, s1_snan;

  // Stage 2 registers (drive the outputs directly)
  logic                         s2_valid;
  logic [LANES-1:0][XW-1:0]     s2_exp;
  logic [LANES-1:0][SW-1:0]     s2_sig;

  // Stage 2 next values
  logic [LANES-1:0][XW-1:0]     nx_exp;
  logic [LANES-1:0][SW-1:0]     nx_sig;

  logic s1_adv, s2_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid;
  assign out_exp   = s2_exp;
  assign out_sig   = s2_sig;

`ifdef FP_UNPACK_SUBNORM_NORM_EN
  localparam int LZ_W = $clog2(MANT_W + 1);

  logic [LANES-1:0][LZ_W-1:0] lz;

  // Leading-zero count of a non-zero mantissa; the highest set bit wins
  function automatic logic [LZ_W-1:0] lzc(input logic [MANT_W-1:0] v);
    logic [LZ_W-1:0] n;
    n = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (v[i]) n = LZ_W'(MANT_W - 1 - i);
    end
    return n;
  endfunction
`endif

  // Classify each incoming lane; a subnormal only counts as zero under DAZ
  always_comb begin
    c_zero = '0;
    c_sub  = '0;
    c_inf  = '0;
    c_nan  = '0;
    c_snan = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
      c_zero[l] = ~(|in_e[l]) & ~(|in_m[l]);
`else
      c_zero[l] = ~(|in_e[l]);
`endif
      c_sub[l]  = ~(|in_e[l]) & (|in_m[l]);
      c_inf[l]  = (&in_e[l]) & ~(|in_m[l]);
      c_nan[l]  = (&in_e[l]) & (|in_m[l]);
      c_snan[l] = (&in_e[l]) & (|in_m[l]) & ~in_m[l][MANT_W-1];
    end
  end

  // Stage 1: capture raw fields and flags whenever the stage can advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_zero  <= '0;
      s1_sub   <= '0;
      s1_inf   <= '0;
      s1_nan   <= '0;
      s1_snan  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_s;
        s1_exp  <= in_e;
        s1_mant <= in_m;
        s1_zero <= c_zero;
        s1_sub  <= c_sub;
        s1_inf  <= c_inf;
        s1_nan  <= c_nan;
        s1_snan <= c_snan;
      end
    end
  end

  // Stage 2 datapath: exponent unbiasing and significand formation per lane
  always_comb begin
    nx_exp = '0;
    nx_sig = '0;
`ifdef FP_UNPACK_SUBNORM_NORM_EN
    lz = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
      lz[l] = lzc(s1_mant[l]);
`endif
      if (s1_nan[l] || s1_inf[l]) begin
        nx_exp[l] = EXP_SPECIAL;
        nx_sig[l] = s1_nan[l] ? {1'b0, s1_mant[l]} : '0;
      end else if (s1_zero[l]) begin
        nx_exp[l] = '0;
        nx_sig[l] = '0;
      end else if (s1_sub[l]) begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
        nx_sig[l] = {1'b0, s1_mant[l]} << (lz[l] + 1'b1);
        nx_exp[l] = '0 - BIAS - XW'(lz[l]);
`else
        nx_exp[l] = '0;
        nx_sig[l] = '0;
`endif
      end else begin
        nx_exp[l] = {2'b00, s1_exp[l]} - BIAS;
        nx_sig[l] = {1'b1, s1_mant[l]};
      end
    end
  end

  // Stage 2: output registers load only when the stage advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sign <= '0;
      s2_exp   <= '0;
      s2_sig   <= '0;
      out_zero <= '0;
      out_sub  <= '0;
      out_inf  <= '0;
      out_nan  <= '0;
      out_snan <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sign <= s1_sign;
        s2_exp   <= nx_exp;
        s2_sig   <= nx_sig;
        out_zero <= s1_zero;
        out_sub  <= s1_sub;
        out_inf  <= s1_inf;
        out_nan  <= s1_nan;
        out_snan <= s1_snan;
      end
    end
  end

endmodule

// File: tb/tb_fp_unpacker_pipe.sv
// tb_fp_unpacker_pipe: directed self-checking bench for fp_unpacker_pipe.
// Main instance is FP32 x4 lanes; a second instance covers FP16 x3 lanes.
// Expected subnormal results follow FP_UNPACK_SUBNORM_NORM_EN.
module tb_fp_unpacker_pipe;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_sign;
  logic [39:0]  out_exp;
  logic [95:0]  out_sig;
  logic [3:0]   out_zero, out_sub, out_inf, out_nan, out_snan;

  logic         h_in_valid;
  logic         h_in_ready;
  logic [47:0]  h_in_data;
  logic         h_out_valid;
  logic         h_out_ready;
  logic [2:0]   h_out_sign;
  logic [20:0]  h_out_exp;
  logic [32:0]  h_out_sig;
  logic [2:0]   h_out_zero, h_out_sub, h_out_inf, h_out_nan, h_out_snan;

  int n_cmp;
  int n_bad;

  fp_unpacker_pipe #(.LANES(4), .EXP_W(8), .MANT_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig),
    .out_zero(out_zero), .out_sub(out_sub), .out_inf(out_inf),
    .out_nan(out_nan), .out_snan(out_snan)
  );

  fp_unpacker_pipe #(.LANES(3), .EXP_W(5), .MANT_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_sign(h_out_sign), .out_exp(h_out_exp), .out_sig(h_out_sig),
    .out_zero(h_out_zero), .out_sub(h_out_sub), .out_inf(h_out_inf),
    .out_nan(h_out_nan), .out_snan(h_out_snan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Normal FP32 word for transfer index i: lane l has sign l[0], e=64+i, m=i*4+l+1
  function automatic logic [127:0] b2b_word(input int i);
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = {1'(l % 2), 8'(64 + i), 23'(i * 4 + l + 1)};
    return r;
  endfunction

  function automatic logic [39:0] b2b_exp(input int i);
    logic [39:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) r[l*10 +: 10] = 10'(64 + i - 127);
    return r;
  endfunction

  function automatic logic [95:0] b2b_sig(input int i);
    logic [95:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) r[l*24 +: 24] = {1'b1, 23'(i * 4 + l + 1)};
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    h_in_valid = 1'b0;
    h_in_data = '0;
    h_out_ready = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_cmp++;
    if ({out_sign, out_exp, out_sig, out_zero, out_sub, out_inf, out_nan, out_snan} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got exp %h sig %h flags %b%b%b%b%b want all zero",
               out_exp, out_sig, out_zero, out_sub, out_inf, out_nan, out_snan);
    end
  endtask

  task automatic test_fp32_basic;
    in_valid = 1'b1;
    in_data = {32'h80000000, 32'h00000000, 32'hC0490FDB, 32'h3F800000};
    tick;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_latency_early: got %b want 0", out_valid);
    end
    tick;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL basic_latency: got %b want 1", out_valid);
    end
    n_cmp++;
    if (out_exp !== {10'd0, 10'd0, 10'd1, 10'd0}) begin
      n_bad++;
      $display("[TB] FAIL basic_exp: got %h want %h", out_exp, {10'd0, 10'd0, 10'd1, 10'd0});
    end
    n_cmp++;
    if (out_sig !== {24'h0, 24'h0, 24'hC90FDB, 24'h800000}) begin
      n_bad++;
      $display("[TB] FAIL basic_sig: got %h want %h", out_sig, {24'h0, 24'h0, 24'hC90FDB, 24'h800000});
    end
    n_cmp++;
    if ({out_zero, out_sign} !== {4'b1100, 4'b1010}) begin
      n_bad++;
      $display("[TB] FAIL basic_zero_sign: got %b %b want 1100 1010", out_zero, out_sign);
    end
    n_cmp++;
    if ({out_sub, out_inf, out_nan, out_snan} !== 16'h0) begin
      n_bad++;
      $display("[TB] FAIL basic_flags: got %b %b %b %b want 0", out_sub, out_inf, out_nan, out_snan);
    end
    tick;
    tick;
  endtask

  task automatic test_specials;
    logic [39:0] e_exp;
    logic [95:0] e_sig;
    logic [3:0]  e_zero;
`ifdef FP_UNPACK_SUBNORM_NORM_EN
    // -149 and -127 as 10-bit two's complement are 0x36B and 0x381
    e_exp  = {10'h080, 10'h080, 10'h381, 10'h36B};
    e_sig  = {24'h200000, 24'h0, 24'h800000, 24'h800000};
    e_zero = 4'b0000;
`else
    e_exp  = {10'h080, 10'h080, 10'h000, 10'h000};
    e_sig  = {24'h200000, 24'h0, 24'h0, 24'h0};
    e_zero = 4'b0011;
`endif
    in_valid = 1'b1;
    in_data = {32'h7FA00000, 32'h7F800000, 32'h00400000, 32'h00000001};
    tick;
    in_valid = 1'b0;
    tick;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL special_valid: got %b want 1", out_valid);
    end
    n_cmp++;
    if (out_exp !== e_exp) begin
      n_bad++;
      $display("[TB] FAIL special_exp: got %h want %h", out_exp, e_exp);
    end
    n_cmp++;
    if (out_sig !== e_sig) begin
      n_bad++;
      $display("[TB] FAIL special_sig: got %h want %h", out_sig, e_sig);
    end
    n_cmp++;
    if ({out_zero, out_sub, out_inf, out_nan, out_snan} !== {e_zero, 4'b0011, 4'b0100, 4'b1000, 4'b1000}) begin
      n_bad++;
      $display("[TB] FAIL special_flags: got z%b s%b i%b n%b sn%b want z%b s0011 i0100 n1000 sn1000",
               out_zero, out_sub, out_inf, out_nan, out_snan, e_zero);
    end
    tick;
    tick;
  endtask

  task automatic test_fp16;
    logic [20:0] e_exp;
    logic [32:0] e_sig;
    logic [2:0]  e_zero;
`ifdef FP_UNPACK_SUBNORM_NORM_EN
    // -24 as 7-bit two's complement is 0x68; NaN exponent is 16
    e_exp  = {7'h10, 7'h68, 7'h00};
    e_sig  = {11'h200, 11'h400, 11'h400};
    e_zero = 3'b000;
`else
    e_exp  = {7'h10, 7'h00, 7'h00};
    e_sig  = {11'h200, 11'h000, 11'h400};
    e_zero = 3'b010;
`endif
    h_in_valid = 1'b1;
    h_in_data = {16'h7E00, 16'h0001, 16'h3C00};
    tick;
    h_in_valid = 1'b0;
    tick;
    n_cmp++;
    if (h_out_valid !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL fp16_valid: got %b want 1", h_out_valid);
    end
    n_cmp++;
    if (h_out_exp !== e_exp) begin
      n_bad++;
      $display("[TB] FAIL fp16_exp: got %h want %h", h_out_exp, e_exp);
    end
    n_cmp++;
    if (h_out_sig !== e_sig) begin
      n_bad++;
      $display("[TB] FAIL fp16_sig: got %h want %h", h_out_sig, e_sig);
    end
    n_cmp++;
    if ({h_out_zero, h_out_sub, h_out_nan, h_out_snan, h_out_inf} !== {e_zero, 3'b010, 3'b100, 3'b000, 3'b000}) begin
      n_bad++;
      $display("[TB] FAIL fp16_flags: got z%b s%b n%b sn%b i%b want z%b s010 n100 sn000 i000",
               h_out_zero, h_out_sub, h_out_nan, h_out_snan, h_out_inf, e_zero);
    end
    tick;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] pattern;
    int sent, rcvd, occ, cyc;
    logic acc_in, acc_out, exp_rdy;
    pattern = 32'b0110_1001_1100_0101_1011_0011_1000_1110;
    sent = 0;
    rcvd = 0;
    occ = 0;
    cyc = 0;
    while (rcvd < 16 && cyc < 200) begin
      in_valid = (sent < 16);
      in_data = b2b_word(sent);
      out_ready = pattern[cyc % 32];
      #4;
      exp_rdy = !(occ == 2 && !out_ready);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_bad++;
        $display("[TB] FAIL b2b_in_ready cycle %0d: got %b want %b", cyc, in_ready, exp_rdy);
      end
      acc_in = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        n_cmp++;
        if ({out_exp, out_sig, out_sign} !== {b2b_exp(rcvd), b2b_sig(rcvd), 4'b1010}) begin
          n_bad++;
          $display("[TB] FAIL b2b_data #%0d: got %h %h want %h %h", rcvd, out_exp, out_sig,
                   b2b_exp(rcvd), b2b_sig(rcvd));
        end
        rcvd++;
      end
      if (acc_in) sent++;
      occ = occ + int'(acc_in) - int'(acc_out);
      cyc++;
      tick;
    end
    n_cmp++;
    if (rcvd != 16) begin
      n_bad++;
      $display("[TB] FAIL b2b_count: got %0d want 16", rcvd);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    tick;
    tick;
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = b2b_word(20);
    tick;
    in_data = b2b_word(21);
    tick;
    in_data = b2b_word(22);
    for (int c = 0; c < 5; c++) begin
      #4;
      n_cmp++;
      if ({in_ready, out_valid, out_exp, out_sig} !== {1'b0, 1'b1, b2b_exp(20), b2b_sig(20)}) begin
        n_bad++;
        $display("[TB] FAIL stall_hold cycle %0d: got rdy %b vld %b %h %h want rdy 0 vld 1 %h %h",
                 c, in_ready, out_valid, out_exp, out_sig, b2b_exp(20), b2b_sig(20));
      end
      tick;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 3);
      in_data = b2b_word(22 + c);
      #4;
      n_cmp++;
      if ({in_ready, out_valid, out_exp, out_sig} !== {1'b1, 1'b1, b2b_exp(20 + c), b2b_sig(20 + c)}) begin
        n_bad++;
        $display("[TB] FAIL stall_release cycle %0d: got rdy %b vld %b %h %h want rdy 1 vld 1 %h %h",
                 c, in_ready, out_valid, out_exp, out_sig, b2b_exp(20 + c), b2b_sig(20 + c));
      end
      tick;
    end
    in_valid = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = b2b_word(30);
    tick;
    in_data = b2b_word(31);
    tick;
    in_valid = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL midreset_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if ({out_sign, out_exp, out_sig, out_zero, out_sub, out_inf, out_nan, out_snan} !== '0) begin
      n_bad++;
      $display("[TB] FAIL midreset_outputs: got exp %h sig %h want all zero", out_exp, out_sig);
    end
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = b2b_word(5);
    tick;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL midreset_early: got %b want 0", out_valid);
    end
    tick;
    n_cmp++;
    if ({out_valid, out_exp, out_sig} !== {1'b1, b2b_exp(5), b2b_sig(5)}) begin
      n_bad++;
      $display("[TB] FAIL midreset_first: got vld %b %h %h want vld 1 %h %h",
               out_valid, out_exp, out_sig, b2b_exp(5), b2b_sig(5));
    end
    tick;
    tick;
  endtask

  // Run every scenario in order, then report
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_fp32_basic;
    test_specials;
    test_fp16;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
